regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
- Owns the single write port (we/wa/wd) of the 32x32 register file.
- Shares that port between the CPU writeback stage and a debug/loader write requester that uses a valid/ready handshake.
- Runs a hardware clear sequence that zeroes x1..x31 after reset or on request.
- Sits between WB and register_file; the read ports are untouched.

Parameters:
- NREG, 32, number of registers; must equal 2**AW.
- AW, 5, address width.
- DW, 32, data width.
- STARVE_LIMIT, 4, consecutive lost cycles after which a pending debug write is forced through; range 1..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- init_req  in  1  single-cycle pulse; starts a clear sequence; honoured only in IDLE.
- cpu_we  in  1  WB write enable.
- cpu_wa  in  AW  WB write address.
- cpu_wd  in  DW  WB write data.
- dbg_valid  in  1  debug write request; held with wa/wd until accepted.
- dbg_wa  in  AW  debug write address.
- dbg_wd  in  DW  debug write data.
- dbg_ready  out  1  debug write accepted this cycle, when dbg_valid and dbg_ready are both 1.
- rf_we  out  1  to register_file we.
- rf_wa  out  AW  to register_file wa.
- rf_wd  out  DW  to register_file wd.
- cpu_stall  out  1  pipeline must hold WB; a stalled cpu_we is not written and is re-presented.
- busy  out  1  clear sequence in progress.

Behaviour:
- States: CLEAR, IDLE. Registers: clr_addr[AW-1:0], starve_cnt[3:0].
- rf_* outputs, dbg_ready and cpu_stall are combinational from state, counters and inputs. A write takes effect at the same clock edge it is presented; the arbiter adds no latency.
- Reset (rstn=0, asynchronous):
  - state=CLEAR, clr_addr=1, starve_cnt=0.
  - Outputs during reset: rf_we=0, rf_wa=0, rf_wd=0, dbg_ready=0, cpu_stall=1, busy=1.
- CLEAR:
  - Drives rf_we=1, rf_wa=clr_addr, rf_wd=0; clr_addr increments each cycle.
  - After the write to address NREG-1, the next state is IDLE and clr_addr reloads to 1. The sequence is exactly NREG-1 = 31 cycles.
  - Throughout CLEAR: cpu_stall=1, busy=1, dbg_ready=0. cpu_we and dbg_valid are ignored, not lost; they are served after CLEAR.
- IDLE to CLEAR: init_req=1 in IDLE moves to CLEAR at the next edge. The current IDLE cycle is still arbitrated normally. init_req during CLEAR is ignored and does not restart the sequence.
- IDLE arbitration, in priority order:
  1. Forced debug: if dbg_valid && starve_cnt==STARVE_LIMIT, grant debug, dbg_ready=1, cpu_stall=cpu_we, starve_cnt cleared to 0.
  2. CPU: if cpu_we && cpu_wa!=0, grant CPU. rf_we=1, rf_wa=cpu_wa, rf_wd=cpu_wd, dbg_ready=0.
     - If dbg_valid, starve_cnt increments, saturating at STARVE_LIMIT; otherwise starve_cnt=0.
  3. Debug: if dbg_valid, grant debug, dbg_ready=1, starve_cnt=0.
  4. Otherwise rf_we=0 and starve_cnt=0.
- Debug grant drives: rf_we=(dbg_wa!=0), rf_wa=dbg_wa, rf_wd=dbg_wd.
- x0 rule:
  - A CPU write to x0 counts as no CPU request, so a pending debug write is granted that cycle.
  - A debug write to x0 is acknowledged (dbg_ready=1) but produces rf_we=0.
  - rf_we is never 1 with rf_wa==0.
- In IDLE, cpu_stall=1 only in the forced-debug cycle with cpu_we=1; otherwise 0. busy=0 in IDLE.
- When rf_we=0, rf_wa and rf_wd are driven to 0.
- Reset mid-CLEAR restarts the sweep at address 1.
- Reset mid-handshake drops the pending debug write. The requester must re-present it after busy falls.

Test Plan:
- Reset release -> busy=1 for 31 cycles; rf_wa sweeps 1..31 with rf_wd=0, rf_we=1; then busy=0. Reading ra1=5 afterwards returns 0.
- IDLE, cpu_we=1 wa=1 wd=32'h1145, no debug -> rf_we=1 rf_wa=1 rf_wd=32'h1145, cpu_stall=0. Next cycle rd1 at ra1=1 returns 32'h1145.
- cpu_we=1 held continuously to wa=2, dbg_valid=1 wa=3 wd=32'h1919, STARVE_LIMIT=4:
  - 4 CPU cycles, then a forced debug cycle with dbg_ready=1 and cpu_stall=1.
  - x3=32'h1919 and starve_cnt returns to 0.
- cpu_we=1 wa=0 with dbg_valid=1 wa=4 wd=32'h114514 -> debug granted the same cycle; rf_wa=4; x0 reads 0.
- dbg_valid=1 wa=0 -> dbg_ready=1 and rf_we=0.
- init_req pulse in IDLE after writing x1=32'h1145:
  - 31-cycle CLEAR; x1 reads 0 afterwards.
  - A cpu_we held during CLEAR sees cpu_stall=1 throughout, and is written in the first IDLE cycle.
  - Deasserting rstn at CLEAR cycle 10 restarts clr_addr at 1 and gives a full 31-cycle sweep.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter for the 32x32 register file: shares the single write port
// between the WB stage and a valid/ready debug writer, and sweeps x1..x(NREG-1)
// to zero after reset or on request.
module regfile_wr_arbiter #(
    parameter int unsigned NREG         = 32,
    parameter int unsigned AW           = 5,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          init_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_wa_i,
    input  logic [DW-1:0] cpu_wd_i,
    input  logic          dbg_valid_i,
    input  logic [AW-1:0] dbg_wa_i,
    input  logic [DW-1:0] dbg_wd_i,
    output logic          dbg_ready_o,
    output logic          rf_we_o,
    output logic [AW-1:0] rf_wa_o,
    output logic [DW-1:0] rf_wd_o,
    output logic          cpu_stall_o,
    output logic          busy_o
);

    typedef enum logic [0:0] {StClear, StIdle} state_e;

    localparam logic [3:0]    Limit    = 4'(STARVE_LIMIT);
    localparam logic [AW-1:0] LastAddr = AW'(NREG - 1);
    localparam logic [AW-1:0] FirstAddr = AW'(1);

    state_e        state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;
    logic [3:0]    starve_cnt_q, starve_cnt_d;

    logic cpu_req;
    logic dbg_grant;

    // A CPU write to x0 is treated as no request at all.
    assign cpu_req = cpu_we_i && (cpu_wa_i != '0);

    // Next-state, arbitration and write-port drive.
    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        starve_cnt_d = starve_cnt_q;
        rf_we_o      = 1'b0;
        rf_wa_o      = '0;
        rf_wd_o      = '0;
        dbg_ready_o  = 1'b0;
        cpu_stall_o  = 1'b0;
        busy_o       = 1'b0;
        dbg_grant    = 1'b0;

        unique case (state_q)
            StClear: begin
                busy_o      = 1'b1;
                cpu_stall_o = 1'b1;
                // Port stays quiet while reset is held even though state is StClear.
                if (rst_ni) begin
                    rf_we_o = 1'b1;
                    rf_wa_o = clr_addr_q;
                end
                if (clr_addr_q == LastAddr) begin
                    state_d    = StIdle;
                    clr_addr_d = FirstAddr;
                end else begin
                    clr_addr_d = clr_addr_q + FirstAddr;
                end
            end
            StIdle: begin
                if (init_req_i) begin
                    state_d = StClear;
                end
                if (dbg_valid_i && (starve_cnt_q == Limit)) begin
                    dbg_grant    = 1'b1;
                    cpu_stall_o  = cpu_we_i;
                    starve_cnt_d = '0;
                end else if (cpu_req) begin
                    rf_we_o = 1'b1;
                    rf_wa_o = cpu_wa_i;
                    rf_wd_o = cpu_wd_i;
                    if (dbg_valid_i) begin
                        starve_cnt_d = (starve_cnt_q == Limit) ? Limit : starve_cnt_q + 4'd1;
                    end else begin
                        starve_cnt_d = '0;
                    end
                end else if (dbg_valid_i) begin
                    dbg_grant    = 1'b1;
                    starve_cnt_d = '0;
                end else begin
                    starve_cnt_d = '0;
                end
                // Debug writes to x0 are acknowledged but never reach the file.
                if (dbg_grant) begin
                    dbg_ready_o = 1'b1;
                    if (dbg_wa_i != '0) begin
                        rf_we_o = 1'b1;
                        rf_wa_o = dbg_wa_i;
                        rf_wd_o = dbg_wd_i;
                    end
                end
            end
            default: begin
                state_d = StClear;
            end
        endcase
    end

    // State, sweep address and starvation counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StClear;
            clr_addr_q   <= FirstAddr;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed table, hand sequences for
// clear/starvation/reset corners, and random traffic against a behavioural model.
module tb_regfile_wr_arbiter;

    localparam int LIMIT = 4;

    typedef struct packed {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        rdy;
        logic        stall;
        logic        busy;
    } out_t;

    typedef struct {
        logic        cwe;
        logic [4:0]  cwa;
        logic [31:0] cwd;
        logic        dv;
        logic [4:0]  dwa;
        logic [31:0] dwd;
        out_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        init_req;
    logic        cpu_we;
    logic [4:0]  cpu_wa;
    logic [31:0] cpu_wd;
    logic        dbg_valid;
    logic [4:0]  dbg_wa;
    logic [31:0] dbg_wd;
    logic        dbg_ready;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        cpu_stall;
    logic        busy;

    int errors = 0;
    int checks = 0;

    // Behavioural model: clearing flag, next address to zero, lost-cycle count.
    bit   m_clr;
    int   m_addr;
    int   m_lost;
    out_t last;

    logic [31:0] dut_rf [32];

    always #5 clk = ~clk;

    regfile_wr_arbiter #(
        .NREG(32), .AW(5), .DW(32), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rstn),
        .init_req_i (init_req),
        .cpu_we_i   (cpu_we),
        .cpu_wa_i   (cpu_wa),
        .cpu_wd_i   (cpu_wd),
        .dbg_valid_i(dbg_valid),
        .dbg_wa_i   (dbg_wa),
        .dbg_wd_i   (dbg_wd),
        .dbg_ready_o(dbg_ready),
        .rf_we_o    (rf_we),
        .rf_wa_o    (rf_wa),
        .rf_wd_o    (rf_wd),
        .cpu_stall_o(cpu_stall),
        .busy_o     (busy)
    );

    // Stand-in register file written only by the DUT's port.
    always @(posedge clk) begin
        if (rf_we) dut_rf[rf_wa] <= rf_wd;
    end

    function automatic out_t mk(logic we, logic [4:0] wa, logic [31:0] wd,
                                logic rdy, logic stall, logic bsy);
        out_t o;
        o.we = we; o.wa = wa; o.wd = wd; o.rdy = rdy; o.stall = stall; o.busy = bsy;
        return o;
    endfunction

    function automatic out_t model_out();
        bit cpu_real, forced, take_dbg;
        if (!rstn) return mk(0, 0, 0, 0, 1, 1);
        if (m_clr) return mk(1, 5'(m_addr), 0, 0, 1, 1);
        cpu_real = cpu_we && (cpu_wa != 0);
        forced   = dbg_valid && (m_lost == LIMIT);
        take_dbg = forced || (dbg_valid && !cpu_real);
        if (take_dbg) begin
            if (dbg_wa != 0) return mk(1, dbg_wa, dbg_wd, 1, forced && cpu_we, 0);
            return mk(0, 0, 0, 1, forced && cpu_we, 0);
        end
        if (cpu_real) return mk(1, cpu_wa, cpu_wd, 0, 0, 0);
        return mk(0, 0, 0, 0, 0, 0);
    endfunction

    task automatic model_reset();
        m_clr = 1; m_addr = 1; m_lost = 0;
    endtask

    task automatic model_advance(out_t o);
        if (!rstn) return;
        if (m_clr) begin
            if (m_addr == 31) begin m_clr = 0; m_addr = 1; end
            else m_addr = m_addr + 1;
        end else begin
            if (o.rdy) m_lost = 0;
            else if (o.we && dbg_valid) m_lost = (m_lost + 1 > LIMIT) ? LIMIT : m_lost + 1;
            else m_lost = 0;
            if (init_req) m_clr = 1;
        end
    endtask

    function automatic out_t dut_out();
        return {rf_we, rf_wa, rf_wd, dbg_ready, cpu_stall, busy};
    endfunction

    task automatic cmp(string name, out_t got, out_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got we=%b wa=%0d wd=%h rdy=%b stall=%b busy=%b, want we=%b wa=%0d wd=%h rdy=%b stall=%b busy=%b",
                     name, got.we, got.wa, got.wd, got.rdy, got.stall, got.busy,
                     exp.we, exp.wa, exp.wd, exp.rdy, exp.stall, exp.busy);
        end
    endtask

    task automatic chk_rf(string name, int idx, logic [31:0] want);
        checks++;
        if (dut_rf[idx] !== want) begin
            errors++;
            $display("FAIL %s: x%0d got %h want %h", name, idx, dut_rf[idx], want);
        end
    endtask

    // Called just after a rising edge with inputs already set; checks against the
    // model (and optionally a literal), then crosses the next rising edge.
    task automatic step(string name, bit use_exp = 0, out_t exp = '0);
        out_t m;
        #2;
        m = model_out();
        cmp({name, "/model"}, dut_out(), m);
        if (use_exp) cmp(name, dut_out(), exp);
        last = m;
        @(posedge clk);
        model_advance(m);
        #1;
    endtask

    task automatic idle_inputs();
        init_req = 0; cpu_we = 0; cpu_wa = 0; cpu_wd = 0;
        dbg_valid = 0; dbg_wa = 0; dbg_wd = 0;
    endtask

    vec_t tbl [7];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) dut_rf[i] = 32'hdead_beef;
        tbl[0] = '{1, 1, 32'h1145, 0, 0, 0, mk(1, 1, 32'h1145, 0, 0, 0)};
        tbl[1] = '{1, 0, 32'hdead, 1, 4, 32'h114514, mk(1, 4, 32'h114514, 1, 0, 0)};
        tbl[2] = '{0, 0, 0, 1, 0, 32'h55, mk(0, 0, 0, 1, 0, 0)};
        tbl[3] = '{0, 9, 32'h77, 0, 6, 32'h66, mk(0, 0, 0, 0, 0, 0)};
        tbl[4] = '{1, 7, 32'ha5, 1, 3, 32'h33, mk(1, 7, 32'ha5, 0, 0, 0)};
        tbl[5] = '{0, 7, 32'ha5, 1, 3, 32'h33, mk(1, 3, 32'h33, 1, 0, 0)};
        tbl[6] = '{1, 31, 32'hffff_ffff, 0, 0, 0, mk(1, 31, 32'hffff_ffff, 0, 0, 0)};

        // Reset with traffic pending, then the post-reset sweep.
        idle_inputs();
        rstn = 0;
        model_reset();
        #1;
        cpu_we = 1; cpu_wa = 12; cpu_wd = 32'hc; dbg_valid = 1; dbg_wa = 13; dbg_wd = 32'hd;
        step("in_reset0", 1, mk(0, 0, 0, 0, 1, 1));
        step("in_reset1", 1, mk(0, 0, 0, 0, 1, 1));
        rstn = 1;
        for (int i = 1; i <= 31; i++) step("sweep", 1, mk(1, 5'(i), 0, 0, 1, 1));
        step("after_sweep_cpu", 1, mk(1, 12, 32'hc, 0, 0, 0));
        cpu_we = 0;
        step("after_sweep_dbg", 1, mk(1, 13, 32'hd, 1, 0, 0));
        idle_inputs();
        chk_rf("sweep_x5", 5, 0);
        chk_rf("sweep_x31", 31, 0);

        // Single-cycle arbitration vectors.
        for (int i = 0; i < 7; i++) begin
            cpu_we = tbl[i].cwe; cpu_wa = tbl[i].cwa; cpu_wd = tbl[i].cwd;
            dbg_valid = tbl[i].dv; dbg_wa = tbl[i].dwa; dbg_wd = tbl[i].dwd;
            step($sformatf("tbl%0d", i), 1, tbl[i].exp);
        end
        idle_inputs();
        chk_rf("tbl_x1", 1, 32'h1145);
        chk_rf("tbl_x4", 4, 32'h114514);

        // Starvation: four CPU wins then a forced debug write, twice in a row.
        cpu_we = 1; cpu_wa = 2; cpu_wd = 32'h22;
        dbg_valid = 1; dbg_wa = 3; dbg_wd = 32'h1919;
        for (int i = 0; i < 4; i++) step("starve_cpu", 1, mk(1, 2, 32'h22, 0, 0, 0));
        step("starve_forced", 1, mk(1, 3, 32'h1919, 1, 1, 0));
        dbg_wa = 8; dbg_wd = 32'h88;
        for (int i = 0; i < 4; i++) step("starve_cpu2", 1, mk(1, 2, 32'h22, 0, 0, 0));
        step("starve_forced2", 1, mk(1, 8, 32'h88, 1, 1, 0));
        idle_inputs();
        chk_rf("starve_x3", 3, 32'h1919);
        chk_rf("starve_x8", 8, 32'h88);

        // init_req clear, with a reset landing at clear cycle 10.
        cpu_we = 1; cpu_wa = 1; cpu_wd = 32'h1145;
        step("pre_init_x1", 1, mk(1, 1, 32'h1145, 0, 0, 0));
        chk_rf("pre_init_x1", 1, 32'h1145);
        init_req = 1; cpu_wa = 5; cpu_wd = 32'h55;
        step("init_cycle", 1, mk(1, 5, 32'h55, 0, 0, 0));
        init_req = 0; cpu_wa = 6; cpu_wd = 32'h66;
        dbg_valid = 1; dbg_wa = 9; dbg_wd = 32'h99;
        for (int i = 1; i <= 9; i++) step("clear", 1, mk(1, 5'(i), 0, 0, 1, 1));
        init_req = 1;
        step("clear_init_ignored", 1, mk(1, 10, 0, 0, 1, 1));
        init_req = 0;
        rstn = 0;
        model_reset();
        step("mid_reset0", 1, mk(0, 0, 0, 0, 1, 1));
        step("mid_reset1", 1, mk(0, 0, 0, 0, 1, 1));
        rstn = 1;
        for (int i = 1; i <= 31; i++) step("resweep", 1, mk(1, 5'(i), 0, 0, 1, 1));
        step("post_clear_cpu", 1, mk(1, 6, 32'h66, 0, 0, 0));
        cpu_we = 0;
        step("post_clear_dbg", 1, mk(1, 9, 32'h99, 1, 0, 0));
        idle_inputs();
        chk_rf("clear_x1", 1, 0);
        chk_rf("clear_x5", 5, 0);
        chk_rf("clear_x6", 6, 32'h66);

        // Random traffic obeying the hold-until-accepted / re-present-on-stall rules.
        last = '0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                rstn = 0;
                model_reset();
                step("rnd_reset");
                rstn = 1;
                dbg_valid = 0;
                continue;
            end
            if (!last.stall) begin
                cpu_we = ($urandom_range(0, 3) != 0);
                cpu_wa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                cpu_wd = $urandom;
            end
            if (!dbg_valid || last.rdy) begin
                dbg_valid = $urandom_range(0, 1) == 1;
                dbg_wa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                dbg_wd = $urandom;
            end
            init_req = ($urandom_range(0, 79) == 0);
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
